// File: rtl/mem_arb.sv
// mem_arb: shares one single-port SRAM between instruction fetch (IFU) and load/store (LSU).
// Define MEM_ARB_STARVE_EN to compile in the IFU anti-starvation counter (limit STARVE_MAX).

module mem_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic [31:0] ifu_a,
  input  logic        ifu_e,
  output logic        ifu_gnt,
  output logic        ifu_rvld,
  output logic [31:0] ifu_rd,
  // load/store port
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_gnt,
  output logic        lsu_rvld,
  output logic [31:0] lsu_rd,
  // shared SRAM port
  output logic [31:0] mem_a,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_re,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IFU  = 2'd1,
    TAG_LSU  = 2'd2
  } tag_e;

  tag_e tag_q, tag_d;

  logic ifu_req;
  logic lsu_req;
  logic ifu_force;
  logic ifu_win;
  logic lsu_win;

  assign ifu_req = ifu_e;
  assign lsu_req = (|lsu_we) | (|lsu_re);

  // Nothing is granted while rst is high, so the SRAM sees no traffic during reset.
  assign ifu_win = !rst && ifu_req && (!lsu_req || ifu_force);
  assign lsu_win = !rst && lsu_req && !ifu_win;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       conflict;

  assign conflict  = ifu_req && lsu_req;
  assign ifu_force = (starve_cnt_q == STARVE_LIM);

  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    starve_cnt_d = starve_cnt_q;
    if (ifu_win) begin
      starve_cnt_d = '0;
    end else if (conflict && lsu_win && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign ifu_force = 1'b0;
`endif

  // The tag remembers which side owns the SRAM read data arriving next cycle.
  always_comb begin
    tag_d = TAG_NONE;
    if (ifu_win) begin
      tag_d = TAG_IFU;
    end else if (lsu_win && (|lsu_re)) begin
      tag_d = TAG_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    ifu_gnt  = ifu_win;
    lsu_gnt  = lsu_win;
    mem_a    = '0;
    mem_we   = '0;
    mem_wd   = '0;
    mem_re   = '0;
    if (ifu_win) begin
      mem_a  = ifu_a;
      mem_re = 4'hF;
    end else if (lsu_win) begin
      mem_a  = lsu_a;
      mem_we = lsu_we;
      mem_wd = lsu_wd;
      mem_re = lsu_re;
    end
  end

  // A read granted just before reset is dropped: rvld and data are masked while rst is high.
  always_comb begin
    ifu_rvld = !rst && (tag_q == TAG_IFU);
    lsu_rvld = !rst && (tag_q == TAG_LSU);
    ifu_rd   = rst ? '0 : mem_rd;
    lsu_rd   = rst ? '0 : mem_rd;
  end

  a_one_grant : assert property (@(posedge clk) !(ifu_gnt && lsu_gnt));
  a_one_rvld  : assert property (@(posedge clk) !(ifu_rvld && lsu_rvld));
  a_param_rng : assert property (@(posedge clk) (STARVE_MAX >= 1) && (STARVE_MAX <= 7));

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level arbitration model.

module tb_mem_arb;

  localparam int unsigned STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  // Grant pattern for a run of conflict cycles starting with an empty starvation history.
  localparam logic [5:0] CONF_IFU = STARVE_ON ? 6'b01_0000 : 6'b00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_a;
  logic        ifu_e;
  logic        ifu_gnt, ifu_rvld;
  logic [31:0] ifu_rd;
  logic [31:0] lsu_a;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_wd;
  logic [3:0]  lsu_re;
  logic        lsu_gnt, lsu_rvld;
  logic [31:0] lsu_rd;
  logic [31:0] mem_a;
  logic [3:0]  mem_we;
  logic [31:0] mem_wd;
  logic [3:0]  mem_re;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_a(ifu_a), .ifu_e(ifu_e), .ifu_gnt(ifu_gnt), .ifu_rvld(ifu_rvld), .ifu_rd(ifu_rd),
    .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
    .lsu_gnt(lsu_gnt), .lsu_rvld(lsu_rvld), .lsu_rd(lsu_rd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_re(mem_re), .mem_rd(mem_rd)
  );

  // Literal per-cycle expectations from the directed part of the stimulus.
  typedef struct {
    bit          on;
    bit          ifu_gnt;
    bit          lsu_gnt;
    bit          ifu_rvld;
    bit          lsu_rvld;
    bit          rd_on;
    logic [31:0] rd;
    logic [3:0]  mem_re;
  } pin_t;

  pin_t pin;
  pin_t no_pin;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [31:0] seed_word(logic [7:0] i);
    return {i, 8'h5A, ~i, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic pin_t mk(bit ig, bit lg, bit ir, bit lr, bit rdon, logic [31:0] rd,
                              logic [3:0] mre);
    pin_t p;
    p.on = 1'b1; p.ifu_gnt = ig; p.lsu_gnt = lg; p.ifu_rvld = ir; p.lsu_rvld = lr;
    p.rd_on = rdon; p.rd = rd; p.mem_re = mre;
    return p;
  endfunction

  // SRAM: 256 words, write-first, one-cycle read latency.
  logic [31:0] sram [256];
  bit   [255:0] sram_wr;

  function automatic logic [31:0] sram_word(logic [7:0] i);
    return sram_wr[i] ? sram[i] : seed_word(i);
  endfunction

  always @(posedge clk) begin
    if (|mem_we) begin
      sram[mem_a[9:2]]    <= merge(sram_word(mem_a[9:2]), mem_wd, mem_we);
      sram_wr[mem_a[9:2]] <= 1'b1;
    end
    if (|mem_re) begin
      mem_rd <= (|mem_we) ? merge(sram_word(mem_a[9:2]), mem_wd, mem_we)
                          : sram_word(mem_a[9:2]);
    end
  end

  // Reference model: its own memory image, lost-conflict streak and pending read.
  logic [31:0] refm [256];
  bit   [255:0] ref_wr;
  int unsigned streak    = 0;
  int          pend_kind = 0;  // 0 none, 1 IFU, 2 LSU
  logic [31:0] pend_data = '0;
  bit          m_ifu_gnt = 1'b0;
  bit          m_lsu_gnt = 1'b0;

  function automatic logic [31:0] ref_word(logic [7:0] i);
    return ref_wr[i] ? refm[i] : seed_word(i);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_and_advance();
    bit          i_req, l_req, i_win, l_win;
    logic [31:0] cur;
    logic [7:0]  li;
    cyc++;
    i_req = ifu_e;
    l_req = (|lsu_we) || (|lsu_re);
    i_win = !rst && i_req && (!l_req || (STARVE_ON && (streak >= STARVE_MAX)));
    l_win = !rst && l_req && !i_win;

    check("ifu_gnt", 32'(ifu_gnt), 32'(i_win));
    check("lsu_gnt", 32'(lsu_gnt), 32'(l_win));
    check("ifu_rvld", 32'(ifu_rvld), 32'(!rst && pend_kind == 1));
    check("lsu_rvld", 32'(lsu_rvld), 32'(!rst && pend_kind == 2));
    check("mem_we", 32'(mem_we), 32'(l_win ? lsu_we : 4'h0));
    check("mem_re", 32'(mem_re), 32'(i_win ? 4'hF : (l_win ? lsu_re : 4'h0)));
    if (rst) begin
      check("ifu_rd_rst", ifu_rd, 32'h0);
      check("lsu_rd_rst", lsu_rd, 32'h0);
    end else if (pend_kind == 1) begin
      check("ifu_rd", ifu_rd, pend_data);
    end else if (pend_kind == 2) begin
      check("lsu_rd", lsu_rd, pend_data);
    end
    if (i_win) check("mem_a_ifu", mem_a, ifu_a);
    if (l_win) begin
      check("mem_a_lsu", mem_a, lsu_a);
      if (|lsu_we) check("mem_wd", mem_wd, lsu_wd);
    end
    if (pin.on) begin
      check("pin_ifu_gnt", 32'(ifu_gnt), 32'(pin.ifu_gnt));
      check("pin_lsu_gnt", 32'(lsu_gnt), 32'(pin.lsu_gnt));
      check("pin_ifu_rvld", 32'(ifu_rvld), 32'(pin.ifu_rvld));
      check("pin_lsu_rvld", 32'(lsu_rvld), 32'(pin.lsu_rvld));
      check("pin_mem_re", 32'(mem_re), 32'(pin.mem_re));
      if (pin.rd_on) check("pin_rd", pin.ifu_rvld ? ifu_rd : lsu_rd, pin.rd);
    end

    m_ifu_gnt = i_win;
    m_lsu_gnt = l_win;
    pend_kind = 0;
    if (rst) begin
      streak = 0;
    end else begin
      if (i_win) streak = 0;
      else if (l_win && i_req && streak < STARVE_MAX) streak++;
      if (l_win) begin
        li  = lsu_a[9:2];
        cur = ref_word(li);
        if (|lsu_we) begin
          cur        = merge(cur, lsu_wd, lsu_we);
          refm[li]   = cur;
          ref_wr[li] = 1'b1;
        end
        if (|lsu_re) begin
          pend_kind = 2;
          pend_data = cur;
        end
      end
      if (i_win) begin
        pend_kind = 1;
        pend_data = ref_word(ifu_a[9:2]);
      end
    end
  endtask

  always @(negedge clk) compare_and_advance();

  task automatic drive(bit r, bit ie, logic [31:0] ia, logic [3:0] we, logic [31:0] wd,
                       logic [3:0] re, logic [31:0] la, pin_t p);
    rst = r; ifu_e = ie; ifu_a = ia;
    lsu_we = we; lsu_wd = wd; lsu_re = re; lsu_a = la;
    pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(pin_t p);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, p);
  endtask

  task automatic reset_cycle();
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0,
          mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          ig;
    logic [3:0]  we, re;
    logic [31:0] a;
    int          kind;

    no_pin = '{default: '0};
    pin    = no_pin;
    rst = 1'b1; ifu_e = 1'b0; ifu_a = '0;
    lsu_we = '0; lsu_wd = '0; lsu_re = '0; lsu_a = '0;
    @(posedge clk);
    #1;
    repeat (3) reset_cycle();

    // IFU-only fetch from 0x100, data next cycle.
    drive(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 4'h0, 32'h0,
          mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'hF));
    idle(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h405A_BFC3, 4'h0));

    // LSU write then read of 0x200.
    drive(1'b0, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 4'h0, 32'h200,
          mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0));
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'hF, 32'h200,
          mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'hF));
    idle(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h0));

    // Six conflict cycles from a clean starvation history.
    reset_cycle();
    for (int k = 0; k < 6; k++) begin
      ig = CONF_IFU[k];
      drive(1'b0, 1'b1, 32'h104, 4'h0, 32'h0, 4'hF, 32'h208,
            mk(ig, !ig, (k > 0) && CONF_IFU[k-1], (k > 0) && !CONF_IFU[k-1], 1'b0, 32'h0, 4'hF));
    end
    idle(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0));

    // IFU read granted, then reset: the read data is never flagged valid.
    drive(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 4'h0, 32'h0,
          mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'hF));
    reset_cycle();
    idle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0));

    // Three lost conflicts, reset, then the full streak must be needed again.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'h10C, 4'h0, 32'h0, 4'hF, 32'h20C,
            mk(1'b0, 1'b1, 1'b0, k > 0, 1'b0, 32'h0, 4'hF));
    end
    reset_cycle();
    for (int k = 0; k < 5; k++) begin
      ig = CONF_IFU[k];
      drive(1'b0, 1'b1, 32'h10C, 4'h0, 32'h0, 4'hF, 32'h20C,
            mk(ig, !ig, (k > 0) && CONF_IFU[k-1], (k > 0) && !CONF_IFU[k-1], 1'b0, 32'h0, 4'hF));
    end
    idle(no_pin);

    // Alternating IFU / LSU reads on every cycle.
    for (int k = 0; k < 8; k++) begin
      a = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      if (k % 2 == 0) begin
        drive(1'b0, 1'b1, a, 4'h0, 32'h0, 4'h0, 32'h0,
              mk(1'b1, 1'b0, 1'b0, k > 0, 1'b0, 32'h0, 4'hF));
      end else begin
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'hF, a,
              mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF));
      end
    end
    idle(no_pin);

    // Random traffic; an ungranted requester holds its request unchanged.
    for (int n = 0; n < 1500; n++) begin
      if (!(ifu_e && !m_ifu_gnt)) begin
        ifu_e = ($urandom_range(0, 2) != 0);
        ifu_a = {22'b0, 8'($urandom_range(0, 31)), 2'b0};
      end
      if (!(((|lsu_we) || (|lsu_re)) && !m_lsu_gnt)) begin
        kind = int'($urandom_range(0, 3));
        we   = (kind == 1 || kind == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        re   = (kind == 2 || kind == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        lsu_we = we;
        lsu_re = re;
        lsu_wd = $urandom;
        lsu_a  = {22'b0, 8'($urandom_range(0, 31)), 2'b0};
      end
      drive($urandom_range(0, 59) == 0, ifu_e, ifu_a, lsu_we, lsu_wd, lsu_re, lsu_a, no_pin);
    end
    idle(no_pin);
    idle(no_pin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
